rom_stream_reader: RTL and testbench
====================================

ROM_STREAM_READER -- requirements
Module: rom_stream_reader

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 Parameter ADDR_WIDTH, default 8: width of the ROM address.
REQ-003 Parameter DATA_WIDTH, default 8: width of the ROM word.
REQ-004 Port list, in this order (name, direction, width, meaning):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a burst.
- start_addr  input  ADDR_WIDTH  first ROM address of the burst.
- length  input  ADDR_WIDTH+1  number of words in the burst, 0..2^ADDR_WIDTH.
- busy  output  1  a burst is in progress.
- done  output  1  one-cycle pulse at the end of a burst.
- rom_addr  output  ADDR_WIDTH  address to the single-port ROM.
- rom_data  input  DATA_WIDTH  ROM read data.
- out_data  output  DATA_WIDTH  stream payload.
- out_valid  output  1  payload is valid.
- out_ready  input  1  consumer accepts the payload.

Function
REQ-005 ROM timing: rom_addr SHALL be registered inside the ROM on clk; rom_data for an address driven in cycle n SHALL be consumed in cycle n+1 only.
REQ-006 FSM states: IDLE, RUN, DRAIN.
REQ-007 IDLE behaviour:
- start=1 with length>0: latch start_addr and length, go to RUN.
- start=1 with length=0: go nowhere, no ROM read, pulse done in the next cycle.
REQ-008 start SHALL be ignored while busy=1.
REQ-009 busy SHALL be 1 in RUN and DRAIN, and 0 in IDLE.
REQ-010 Read issue in RUN: one read issued per cycle, while (FIFO entries + reads in flight − pop this cycle) < 2.
- rom_addr SHALL advance by 1 per issued read.
- Address wraps from 2^ADDR_WIDTH−1 to 0.
REQ-011 rom_addr SHALL hold its last value when no read is issued.
REQ-012 Read data SHALL be written into an internal 2-entry FIFO at the end of the cycle after issue; the FIFO SHALL never overflow.
REQ-013 out_data/out_valid SHALL come from the FIFO head; a pop SHALL occur on out_valid=1 and out_ready=1 at the same clock edge.
REQ-014 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-015 Latency: start sampled at edge 0 -> rom_addr=start_addr in cycle 1 -> out_valid=1 in cycle 3.
REQ-016 Throughput: with out_ready held at 1, the block SHALL sustain one word per cycle with no bubbles.
REQ-017 After the last read is issued, RUN SHALL go to DRAIN.
REQ-018 DRAIN SHALL go to IDLE on the handshake of the final word.
REQ-019 done SHALL be a 1-cycle pulse in the first IDLE cycle after a burst, with busy=0 in that cycle.
REQ-020 A new start SHALL be accepted in the same cycle that done is high.
REQ-021 Exactly length words SHALL be delivered, in address order, with no duplicates or drops under any out_ready pattern.
REQ-022 length=2^ADDR_WIDTH SHALL read every address once, wrapping when start_addr≠0.

Reset
REQ-023 Reset SHALL take effect asynchronously and set:
- FSM to IDLE.
- FIFO empty, no read in flight.
- busy=0, done=0, out_valid=0, rom_addr=0.
REQ-024 Reset asserted mid-burst SHALL abort the burst without a done pulse; out_valid=0 SHALL be observed in the same cycle as the reset assertion.

Verification
Test setup: ROM contents mem[a] = a XOR 8'h5A.
REQ-025 Basic burst: start_addr=8'h10, length=4, out_ready=1 -> out_data 4A,4B,48,49 in cycles 3-6; done pulse in cycle 7.
REQ-026 Wrap-around: start_addr=8'hFE, length=4 -> addresses FE,FF,00,01; out_data A4,A5,5A,5B.
REQ-027 Backpressure: length=8, out_ready random at 50% -> all 8 words in order, out_data stable while stalled, FIFO never more than 2 entries.
REQ-028 Zero length: length=0 -> no rom_addr change, no out_valid, done pulse 1 cycle after start.
REQ-029 Reset mid-burst: rst asserted after 3 of 10 words -> out_valid and busy drop immediately, no done pulse; a new start then produces a correct burst.
REQ-030 Start while busy: start pulsed during a burst -> ignored; the burst count is unchanged.

Source files
------------

// File: rtl/rom_stream_reader.sv
// Streams a burst of consecutive words from a registered single-port ROM
// through a 2-entry FIFO onto a valid/ready output.
module rom_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH:0]   issue_left_reg, issue_left_next;
  logic [ADDR_WIDTH:0]   deliver_left_reg, deliver_left_next;
  logic                  done_reg, done_next;
  logic                  inflight_reg;
  logic                  issue;

  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr_reg, rd_ptr_reg;
  logic [1:0]            count_reg;
  logic                  push, pop;
  logic [2:0]            occ;

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign rom_addr  = addr_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = fifo_mem[rd_ptr_reg];
  assign pop       = out_valid && out_ready;
  // The read issued last cycle has its data on rom_data now.
  assign push      = inflight_reg;

  // Words that will occupy the FIFO once the in-flight read lands; a new
  // read is safe only while this stays below the FIFO depth.
  assign occ = 3'(count_reg) + 3'(inflight_reg) - 3'(pop);

  always_comb begin
    state_next        = state_reg;
    addr_next         = addr_reg;
    issue_left_next   = issue_left_reg;
    deliver_left_next = deliver_left_reg;
    done_next         = 1'b0;
    issue             = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_next        = RUN;
            addr_next         = start_addr;
            issue_left_next   = length;
            deliver_left_next = length;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (occ < 3'd2) begin
          issue           = 1'b1;
          addr_next       = addr_reg + 1'b1;
          issue_left_next = issue_left_reg - 1'b1;
          if (issue_left_reg == 1) state_next = DRAIN;
        end
      end
      DRAIN: begin
      end
      default: state_next = IDLE;
    endcase
    // The final word can only be handed over in DRAIN, after all reads issued.
    if (pop && state_reg != IDLE) begin
      deliver_left_next = deliver_left_reg - 1'b1;
      if (deliver_left_reg == 1) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      addr_reg         <= '0;
      issue_left_reg   <= '0;
      deliver_left_reg <= '0;
      done_reg         <= 1'b0;
      inflight_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      addr_reg         <= addr_next;
      issue_left_reg   <= issue_left_next;
      deliver_left_reg <= deliver_left_next;
      done_reg         <= done_next;
      inflight_reg     <= issue;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage needs no reset; validity is carried by count_reg.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= rom_data;
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader against a registered ROM model
// holding mem[a] = a ^ 8'h5A.
module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] start_addr;
  logic [8:0] length;
  logic       busy, done;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  int checks   = 0;
  int failures = 0;

  rom_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .length(length), .busy(busy), .done(done), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom_addr ^ 8'h5A;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_burst(input logic [7:0] a, input logic [8:0] len,
                           input bit rand_ready, input bit inject);
    int         got;
    int         cyc;
    bit         seen_done;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic [7:0] ea;
    start = 1'b1; start_addr = a; length = len;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1 start = 1'b0;
    got = 0; cyc = 0; seen_done = 0; prev_stall = 0; prev_data = '0;
    while (!seen_done && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (inject && cyc == 2) begin
        start = 1'b1; start_addr = 8'hC0; length = 9'd5;
      end
      if (inject && cyc == 3) start = 1'b0;
      if (prev_stall) check("stall_hold", {31'd0, out_valid} << 8 | 32'(out_data),
                            {23'd0, 1'b1, prev_data});
      if (done) begin
        seen_done = 1;
        check("done_busy", 32'(busy), 32'd0);
      end else begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (out_valid && out_ready) begin
        ea = a + got[7:0];
        check("word", 32'(out_data), 32'(ea ^ 8'h5A));
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    check("done_seen", 32'(seen_done), 32'd1);
    check("word_count", 32'(got), 32'(len));
    $display("burst addr=%02h len=%0d words=%0d cycles=%0d", a, len, got, cyc);
  endtask

  logic [7:0] exp_b [4];

  initial begin
    int got;
    int cyc;
    exp_b = '{8'h4A, 8'h4B, 8'h48, 8'h49};
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic burst with exact cycle timing.
    @(negedge clk);
    out_ready = 1'b1; start = 1'b1; start_addr = 8'h10; length = 9'd4;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) check("b_addr", 32'(rom_addr), 32'h10);
      check("b_valid", 32'(out_valid), 32'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) check("b_data", 32'(out_data), 32'(exp_b[c-3]));
      check("b_done", 32'(done), 32'(c == 7));
      check("b_busy", 32'(busy), 32'(c < 7));
    end
    $display("burst addr=10 len=4 timed");

    // Zero-length start issued in the done cycle.
    start = 1'b1; start_addr = 8'h77; length = 9'd0;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("z_done", 32'(done), 32'd1);
    check("z_busy", 32'(busy), 32'd0);
    check("z_valid", 32'(out_valid), 32'd0);
    check("z_addr", 32'(rom_addr), 32'h14);
    @(negedge clk);
    check("z_done_end", 32'(done), 32'd0);
    check("z_addr_end", 32'(rom_addr), 32'h14);
    $display("burst addr=77 len=0");

    run_burst(8'hFE, 9'd4, 0, 0);
    run_burst(8'h30, 9'd8, 1, 0);
    run_burst(8'h60, 9'd6, 1, 1);
    run_burst(8'h05, 9'd256, 0, 0);

    // Reset in the middle of a 10-word burst.
    start = 1'b1; start_addr = 8'h80; length = 9'd10; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    got = 0; cyc = 0;
    while (got < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) got++;
    end
    check("r_three_words", 32'(got), 32'd3);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("r_valid", 32'(out_valid), 32'd0);
    check("r_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("r_no_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("r_no_done_after", 32'(done), 32'd0);
    check("r_addr", 32'(rom_addr), 32'd0);
    $display("burst addr=80 len=10 aborted after %0d words", got);
    run_burst(8'h40, 9'd3, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
